// File: rtl/multi_debouncer.sv
// Multi-channel debouncer: per-channel synchroniser, stability counter and
// registered level / rise / fall outputs plus a combined change strobe.
module multi_debouncer #(
  parameter int                  CHANNELS       = 4,
  parameter int                  DEBOUNCE_COUNT = 65_536,
  parameter int                  SYNC_STAGES    = 2,
  parameter logic [CHANNELS-1:0] INIT_VALUE     = {CHANNELS{1'b0}}
) (
  input  logic                sys_clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] in_sig,
  output logic [CHANNELS-1:0] out_sig,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic                changed
);

  localparam int CW = (DEBOUNCE_COUNT > 1) ? $clog2(DEBOUNCE_COUNT) : 1;
  localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_COUNT - 1);

  logic [CHANNELS-1:0] level_q;
  logic [CHANNELS-1:0] rise_nxt;
  logic [CHANNELS-1:0] fall_nxt;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   p_q;
    logic                   lvl_q;
    logic [CW-1:0]          ctr_q;
    logic                   s;
    logic                   upd;

    assign s   = sync_q[SYNC_STAGES-1];
    // Terminal count with a stable sample: the level is re-sampled this edge.
    assign upd = (s == p_q) && (ctr_q == TERM);

    assign rise_nxt[i] = upd & ~lvl_q &  p_q;
    assign fall_nxt[i] = upd &  lvl_q & ~p_q;
    assign level_q[i]  = lvl_q;

    always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
        sync_q <= {SYNC_STAGES{INIT_VALUE[i]}};
      end else begin
        sync_q[0] <= in_sig[i];
        for (int k = 1; k < SYNC_STAGES; k++) begin
          sync_q[k] <= sync_q[k-1];
        end
      end
    end

    always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
        p_q   <= INIT_VALUE[i];
        lvl_q <= INIT_VALUE[i];
        ctr_q <= '0;
      end else begin
        p_q <= s;
        if (s != p_q) begin
          ctr_q <= '0;
        end else if (ctr_q == TERM) begin
          ctr_q <= '0;
          lvl_q <= p_q;
        end else begin
          ctr_q <= ctr_q + 1'b1;
        end
      end
    end
  end

  assign out_sig = level_q;

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      rise    <= '0;
      fall    <= '0;
      changed <= 1'b0;
    end else begin
      rise    <= rise_nxt;
      fall    <= fall_nxt;
      changed <= |(rise_nxt | fall_nxt);
    end
  end

endmodule

// File: tb/tb_multi_debouncer.sv
// Bench for multi_debouncer: three configurations driven by one directed
// sequence; dut_a events are checked through an expected-event queue.
module tb_multi_debouncer;

  logic sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  // dut_a: 4 channels, window 4, 2 sync stages, reset level 0
  logic       rst_a;
  logic [3:0] in_a, out_a, rise_a, fall_a;
  logic       changed_a;
  // dut_b: same timing, reset level 4'b0101
  logic       rst_b;
  logic [3:0] in_b, out_b, rise_b, fall_b;
  logic       changed_b;
  // dut_c: single channel, window 2, 1 sync stage
  logic       rst_c;
  logic [0:0] in_c, out_c, rise_c, fall_c;
  logic       changed_c;

  multi_debouncer #(.CHANNELS(4), .DEBOUNCE_COUNT(4), .SYNC_STAGES(2), .INIT_VALUE(4'b0000)) dut_a (
    .sys_clk(sys_clk), .rst(rst_a), .in_sig(in_a), .out_sig(out_a),
    .rise(rise_a), .fall(fall_a), .changed(changed_a));

  multi_debouncer #(.CHANNELS(4), .DEBOUNCE_COUNT(4), .SYNC_STAGES(2), .INIT_VALUE(4'b0101)) dut_b (
    .sys_clk(sys_clk), .rst(rst_b), .in_sig(in_b), .out_sig(out_b),
    .rise(rise_b), .fall(fall_b), .changed(changed_b));

  multi_debouncer #(.CHANNELS(1), .DEBOUNCE_COUNT(2), .SYNC_STAGES(1), .INIT_VALUE(1'b0)) dut_c (
    .sys_clk(sys_clk), .rst(rst_c), .in_sig(in_c), .out_sig(out_c),
    .rise(rise_c), .fall(fall_c), .changed(changed_c));

  int passed = 0;
  int total  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic wait_until(input int n);
    while (cyc < n) tick();
  endtask

  // Expected dut_a events: {cycle[31:0], rise[3:0], fall[3:0]}
  logic [39:0] exp_q[$];
  logic        mon_en = 1'b0;

  always @(negedge sys_clk) begin
    if (mon_en) begin
      if ((rise_a != 4'd0) || (fall_a != 4'd0) || changed_a ||
          ((exp_q.size() != 0) && (exp_q[0][39:8] == cyc))) begin
        if (exp_q.size() == 0) begin
          check("unexpected_event", {cyc, rise_a, fall_a, 3'd0, changed_a}, {cyc, 8'd0, 4'd0});
        end else begin
          logic [39:0] e;
          e = exp_q.pop_front();
          check("event", {cyc, rise_a, fall_a}, e);
          check("changed", changed_a, |e[7:0]);
        end
      end
    end
  end

  task automatic wait_drain();
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) tick();
    check("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k;
    int r;
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    in_a = 4'b0000; in_b = 4'b0101; in_c = 1'b0;
    repeat (3) tick();

    check("a_reset_out",    out_a, 4'b0000);
    check("a_reset_pulses", {rise_a, fall_a, changed_a}, 9'd0);
    check("b_reset_out",    out_b, 4'b0101);
    check("c_reset_out",    out_c, 1'b0);
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    mon_en = 1'b1;

    // Stable input equal to reset level: no event over three windows
    for (int i = 0; i < 14; i++) begin
      tick();
      check("b_quiet_out",    out_b, 4'b0101);
      check("b_quiet_pulses", {rise_b, fall_b, changed_b}, 9'd0);
    end

    // Clean step on channel 0: capture edge k+1, update at k+1+2+4
    k = cyc; in_a[0] = 1'b1;
    exp_q.push_back({32'(k + 7), 4'b0001, 4'b0000});
    wait_drain();
    tick();
    check("a_step_level", out_a, 4'b0001);

    // Bounce on channel 1 with toggles every 3 cycles, then hold 0
    for (int i = 0; i < 40; i++) begin
      if (i % 3 == 0) in_a[1] = ~in_a[1];
      tick();
    end
    in_a[1] = 1'b0;
    repeat (20) tick();
    check("a_bounce_level", out_a, 4'b0001);

    // Hold 1 on channel 1
    k = cyc; in_a[1] = 1'b1;
    exp_q.push_back({32'(k + 7), 4'b0010, 4'b0000});
    wait_drain();

    // Bring channel 3 high, then swap channels 2 and 3 on one edge
    k = cyc; in_a[3] = 1'b1;
    exp_q.push_back({32'(k + 7), 4'b1000, 4'b0000});
    wait_drain();
    repeat (3) tick();
    k = cyc; in_a[2] = 1'b1; in_a[3] = 1'b0;
    exp_q.push_back({32'(k + 7), 4'b0100, 4'b1000});
    wait_drain();
    repeat (3) tick();
    check("a_final_level", out_a, 4'b0111);

    // Reset 2 cycles before dut_b's pending update on channel 1
    k = cyc; in_b = 4'b0111;
    wait_until(k + 5);
    rst_b = 1'b1;
    tick();
    check("b_in_reset_out",    out_b, 4'b0101);
    check("b_in_reset_pulses", {rise_b, fall_b, changed_b}, 9'd0);
    tick();
    rst_b = 1'b0;
    r = cyc;
    while (cyc < r + 6) begin
      tick();
      check("b_post_reset_out",    out_b, 4'b0101);
      check("b_post_reset_pulses", {rise_b, fall_b, changed_b}, 9'd0);
    end
    tick();
    check("b_update_out",    out_b, 4'b0111);
    check("b_update_pulses", {rise_b, fall_b, changed_b}, {4'b0010, 4'b0000, 1'b1});
    tick();
    check("b_pulse_end", {rise_b, fall_b, changed_b}, 9'd0);

    // Single-cycle glitch on dut_c is rejected
    in_c = 1'b1;
    tick();
    in_c = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("c_glitch", {out_c, rise_c, fall_c, changed_c}, 4'd0);
    end

    // Three-cycle hold: capture k+1, update at k+4; release gives fall at k+7
    k = cyc; in_c = 1'b1;
    repeat (3) tick();
    in_c = 1'b0;
    wait_until(k + 3);
    check("c_hold_before", {out_c, rise_c}, 2'b00);
    wait_until(k + 4);
    check("c_hold_rise", {out_c, rise_c, fall_c, changed_c}, 4'b1101);
    wait_until(k + 5);
    check("c_rise_end", {out_c, rise_c, changed_c}, 3'b100);
    wait_until(k + 6);
    check("c_before_fall", {out_c, fall_c}, 2'b10);
    wait_until(k + 7);
    check("c_fall", {out_c, rise_c, fall_c, changed_c}, 4'b0011);

    repeat (4) tick();
    check("a_queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
